led_chain_tx: RTL and testbench

LED_CHAIN_TX -- requirements
Module: led_chain_tx

---
 rtl/led_pkg.sv | 22 ++
 rtl/led_clk_div.sv | 44 ++++
 rtl/led_chain_tx.sv | 143 ++++++++++++++
 tb/tb_led_chain_tx.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and default parameters for the LED chain transmitter.
// Holds the FSM state type, default sizing constants and a max helper.
package led_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_LATCH,
        ST_GAP
    } led_state_t;

    localparam int DEF_NUM_CH       = 2;
    localparam int DEF_LED_NUM      = 4;
    localparam int DEF_BITS_PER_LED = 32;
    localparam int DEF_CLK_DIV      = 2;
    localparam int DEF_GAP_CNT      = 5;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/led_clk_div.sv
// Serial clock phase generator: cko low for CLK_DIV cycles, then high.
// Ports: clk, rstn, run (advance), clear (sync reset), cko, bit_tick.
module led_clk_div
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic run,
    input  logic clear,
    output logic cko,
    output logic bit_tick
);

    localparam int CW = $clog2(CLK_DIV + 1);

    logic [CW-1:0] cnt_q;
    logic          ph_q;
    logic          half_end;

    assign half_end = (cnt_q == CW'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
            ph_q  <= 1'b0;
        end else if (clear) begin
            cnt_q <= '0;
            ph_q  <= 1'b0;
        end else if (run) begin
            if (half_end) begin
                cnt_q <= '0;
                ph_q  <= ~ph_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign cko = ph_q;
    // Last cycle of a bit's high phase: the data may advance next.
    assign bit_tick = run & ph_q & half_end;

endmodule

// File: rtl/led_chain_tx.sv
// Multi-chain LED frame transmitter, MSB first, shared cko.
// Ports: clk, rstn, start, data_in, ch_en -> busy, done, cko, sdo, lat.
// Macro LED_LATCH_EN adds a latch strobe phase after shifting.
module led_chain_tx
    import led_pkg::*;
#(
    parameter int NUM_CH       = DEF_NUM_CH,
    parameter int LED_NUM      = DEF_LED_NUM,
    parameter int BITS_PER_LED = DEF_BITS_PER_LED,
    parameter int CLK_DIV      = DEF_CLK_DIV,
    parameter int GAP_CNT      = DEF_GAP_CNT
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              start,
    input  logic [NUM_CH*LED_NUM*BITS_PER_LED-1:0] data_in,
    input  logic [NUM_CH-1:0]                 ch_en,
    output logic                              busy,
    output logic                              done,
    output logic                              cko,
    output logic [NUM_CH-1:0]                 sdo,
    output logic                              lat
);

    localparam int FRAME_W = LED_NUM * BITS_PER_LED;
    localparam int BW      = $clog2(FRAME_W + 1);
    localparam int LAT_LEN = 2 * CLK_DIV;
    localparam int TW      = $clog2(max_int(LAT_LEN, GAP_CNT) + 1);

    led_state_t state_q, state_d;

    logic [NUM_CH-1:0][FRAME_W-1:0] shreg_q;
    logic [NUM_CH-1:0]              en_q;
    logic [BW-1:0]                  bit_q;
    logic [TW-1:0]                  tmr_q;

    logic run;
    logic bit_tick;
    logic load;
    logic last_bit;
    logic shifting;

    assign load     = (state_q == ST_IDLE) && start;
    assign shifting = (state_q == ST_SHIFT);
    assign last_bit = bit_tick && (bit_q == BW'(FRAME_W - 1));

    led_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk      (clk),
        .rstn     (rstn),
        .run      (run),
        .clear    (~run),
        .cko      (cko),
        .bit_tick (bit_tick)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b1;
        done    = 1'b0;
        lat     = 1'b0;
        run     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                run = 1'b1;
                if (last_bit) begin
`ifdef LED_LATCH_EN
                    state_d = ST_LATCH;
`else
                    state_d = ST_GAP;
`endif
                end
            end
            ST_LATCH: begin
`ifdef LED_LATCH_EN
                lat = 1'b1;
                if (tmr_q == TW'(LAT_LEN - 1)) begin
                    state_d = ST_GAP;
                end
`else
                state_d = ST_GAP;
`endif
            end
            ST_GAP: begin
                if (tmr_q == TW'(GAP_CNT - 1)) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Frame data and per-phase counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shreg_q <= '0;
            en_q    <= '0;
            bit_q   <= '0;
            tmr_q   <= '0;
        end else begin
            if (load) begin
                shreg_q <= data_in;
                en_q    <= ch_en;
                bit_q   <= '0;
            end else if (shifting && bit_tick) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    shreg_q[c] <= shreg_q[c] << 1;
                end
                bit_q <= bit_q + 1'b1;
            end
            // Timer restarts on every state change.
            if (state_d != state_q) begin
                tmr_q <= '0;
            end else if (state_q == ST_LATCH || state_q == ST_GAP) begin
                tmr_q <= tmr_q + 1'b1;
            end
        end
    end

    always_comb begin
        sdo = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            sdo[c] = shifting & en_q[c] & shreg_q[c][FRAME_W-1];
        end
    end

endmodule

// File: tb/tb_led_chain_tx.sv
// Scoreboard bench for led_chain_tx with randomized frames.
// Expected frames are queued by stimulus and checked by a monitor.
module tb_led_chain_tx;

    localparam int FW = 128;

`ifdef LED_LATCH_EN
    localparam int DONE_OFF = 520;
    localparam int LAT_CYC  = 4;
`else
    localparam int DONE_OFF = 516;
    localparam int LAT_CYC  = 0;
`endif

    typedef struct {
        logic [255:0] data;
        logic [1:0]   en;
        bit           aborted;
        bit           b2b;
    } exp_t;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         start = 1'b0;
    logic [255:0] data_in = '0;
    logic [1:0]   ch_en = '0;
    logic         busy;
    logic         done;
    logic         cko;
    logic [1:0]   sdo;
    logic         lat;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    exp_t expq[$];

    led_chain_tx dut (
        .clk     (clk),
        .rstn    (rstn),
        .start   (start),
        .data_in (data_in),
        .ch_en   (ch_en),
        .busy    (busy),
        .done    (done),
        .cko     (cko),
        .sdo     (sdo),
        .lat     (lat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] got,
                       input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     name, got, exp, cyc);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // ---------------- monitor ----------------
    exp_t         cur;
    bit           in_frame = 0;
    int           t1 = 0;
    int           nrise = 0;
    int           latn = 0;
    int           latfirst = -1;
    int           last_done = 0;
    logic [FW-1:0] got_w [2];
    logic         busy_p = 0;
    logic         cko_p = 0;
    logic [1:0]   sdo_p = '0;

    always @(negedge clk) begin
        if (!rstn) begin
            chk("rst_outputs", {busy, done, cko, lat, sdo}, '0);
            if (in_frame) begin
                chk("abort_expected", cur.aborted, 1);
                in_frame = 0;
            end
        end else begin
            if (busy && !busy_p) begin
                if (expq.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                end else begin
                    cur = expq.pop_front();
                    in_frame = 1;
                    t1 = cyc;
                    nrise = 0;
                    latn = 0;
                    latfirst = -1;
                    got_w[0] = '0;
                    got_w[1] = '0;
                    if (cur.b2b) chk("b2b_gap", cyc - last_done, 2);
                end
            end
            if (!busy && busy_p) chk("busy_fall", cyc - last_done, 1);
            if (in_frame) begin
                if (cko && !cko_p) begin
                    nrise++;
                    for (int c = 0; c < 2; c++)
                        got_w[c] = {got_w[c][FW-2:0], sdo[c]};
                end
                if (cko && cko_p) chk("sdo_stable", sdo, sdo_p);
                chk("sdo_disabled", sdo & ~cur.en, '0);
                if (lat) begin
                    latn++;
                    if (latfirst < 0) latfirst = cyc - t1;
                    chk("lat_cko", cko, 0);
                end
                if (done) begin
                    chk("done_time", cyc - t1, DONE_OFF);
                    chk("not_aborted", cur.aborted, 0);
                    chk("cko_rises", nrise, FW);
                    for (int c = 0; c < 2; c++)
                        chk($sformatf("word_ch%0d", c), got_w[c],
                            cur.en[c] ? cur.data[c*FW +: FW] : '0);
                    chk("lat_cycles", latn, LAT_CYC);
                    if (LAT_CYC > 0) chk("lat_start", latfirst, 512);
                    last_done = cyc;
                    in_frame = 0;
                end else if (!busy) begin
                    chk("done_missing", 0, 1);
                    in_frame = 0;
                end
            end else begin
                chk("stray_done", done, 0);
                if (!busy) chk("idle_outputs", {cko, lat, sdo}, '0);
            end
        end
        busy_p = busy;
        cko_p = cko;
        sdo_p = sdo;
    end

    // ---------------- stimulus ----------------
    task automatic wait_idle();
        int n = 0;
        while (busy && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    task automatic start_frame(input logic [255:0] d, input logic [1:0] en,
                               input bit abort_it);
        exp_t e;
        @(posedge clk);
        #1;
        data_in = d;
        ch_en = en;
        start = 1'b1;
        e.data = d;
        e.en = en;
        e.aborted = abort_it;
        e.b2b = 0;
        expq.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        data_in = rand256();
        ch_en = 2'($urandom);
    endtask

    initial begin
        logic [255:0] pat;
        exp_t e;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (3) @(posedge clk);

        // Alternating pattern on both chains.
        pat = {64{4'h5}};
        start_frame(pat, 2'b11, 0);
        wait_idle();

        // Known word on ch0, ch1 disabled.
        pat = rand256();
        pat[127:0] = 128'h12345678_9ABCDEF0_0F0F0F0F_FFFF0000;
        start_frame(pat, 2'b01, 0);
        wait_idle();

        // Start pulsed mid-frame is ignored.
        start_frame(rand256(), 2'b11, 0);
        repeat (98) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();

        // Reset at T+200 aborts the frame.
        start_frame(rand256(), 2'b11, 1);
        repeat (199) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_reset", {busy, done, cko, lat, sdo}, '0);
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("no_resume", busy, 0);

        // Back-to-back with start held high.
        @(posedge clk);
        #1;
        pat = rand256();
        data_in = pat;
        ch_en = 2'b11;
        start = 1'b1;
        e.data = pat;
        e.en = 2'b11;
        e.aborted = 0;
        e.b2b = 0;
        expq.push_back(e);
        @(posedge clk);
        #1;
        pat = rand256();
        data_in = pat;
        ch_en = 2'b10;
        e.data = pat;
        e.en = 2'b10;
        e.b2b = 1;
        expq.push_back(e);
        wait_idle();
        @(posedge clk);
        #1;
        chk("b2b_accept", busy, 1);
        start = 1'b0;
        data_in = rand256();
        wait_idle();

        // Random frames.
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(1, 5)) @(posedge clk);
            start_frame(rand256(), 2'($urandom), 0);
            wait_idle();
        end

        repeat (10) @(posedge clk);
        #1;
        chk("queue_empty", expq.size(), 0);
        chk("frame_closed", in_frame, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
